// File: rtl/psum_accum_binarize_pkg.sv
// Shared definitions for the psum accumulate/binarize stage: default sizes,
// FSM encoding and the MSB-first lane packing used by the PE column.
package psum_accum_binarize_pkg;

    localparam int WIDTH_DEF     = 14;
    localparam int O_CH_DEF      = 64;
    localparam int ACC_WIDTH_DEF = 18;
    localparam int MAX_TILES_DEF = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Lane 0 occupies the most significant slice of a packed bus.
    function automatic int lane_lsb(input int lane, input int lane_w, input int lanes);
        return lane_w * (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/psum_accum_binarize_acc_lane.sv
// One output channel: signed accumulator, tile adder and threshold compare.
// Define ACC_SAT_EN for saturating adds; otherwise the sum wraps.
module psum_accum_binarize_acc_lane #(
    parameter int WIDTH     = 14,
    parameter int ACC_WIDTH = 18
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        accept,
    input  logic                        last,
    input  logic signed [WIDTH-1:0]     psum,
    input  logic signed [ACC_WIDTH-1:0] threshold,
    output logic                        act
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_wide;
    assign sum_wide = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(psum);

    // Overflow shows up as disagreement between the two top bits.
    always_comb begin
        sum = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
            sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
`else
    assign sum = acc + ACC_WIDTH'(psum);
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc <= '0;
            act <= 1'b0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                act <= (sum >= threshold);
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/psum_accum_binarize.sv
// Accumulates per-channel psums across input-channel tiles and binarizes the
// totals against per-channel thresholds. Optional macro: ACC_SAT_EN.
module psum_accum_binarize
    import psum_accum_binarize_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int O_CH      = O_CH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int MAX_TILES = MAX_TILES_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      psum_valid_in,
    output logic                      psum_ready_out,
    input  logic [WIDTH*O_CH-1:0]     psum_in,
    input  logic                      last_tile_in,
    input  logic [ACC_WIDTH*O_CH-1:0] threshold_in,
    output logic                      act_valid_out,
    input  logic                      act_ready_in,
    output logic [O_CH-1:0]           act_out,
    output logic                      tile_overflow_out
);

    localparam int CNT_W = (MAX_TILES > 2) ? $clog2(MAX_TILES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TILES - 1);

    state_t           state;
    logic [CNT_W-1:0] tile_cnt;
    logic             accept;

    // Ready while the result slot is empty or being drained this cycle.
    assign psum_ready_out = !act_valid_out || act_ready_in;
    assign accept         = psum_valid_in && psum_ready_out;
    assign act_valid_out  = (state == HOLD);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= ACCUM;
            tile_cnt          <= '0;
            tile_overflow_out <= 1'b0;
        end else if (accept) begin
            if (last_tile_in) begin
                state    <= HOLD;
                tile_cnt <= '0;
            end else begin
                state <= ACCUM;
                if (tile_cnt == CNT_MAX)
                    tile_overflow_out <= 1'b1;
                else
                    tile_cnt <= tile_cnt + CNT_W'(1);
            end
        end else if (state == HOLD && act_ready_in) begin
            state <= ACCUM;
        end
    end

    for (genvar k = 0; k < O_CH; k++) begin : g_lane
        localparam int PS_LSB = lane_lsb(k, WIDTH, O_CH);
        localparam int TH_LSB = lane_lsb(k, ACC_WIDTH, O_CH);
        logic act_bit;

        psum_accum_binarize_acc_lane #(
            .WIDTH    (WIDTH),
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .accept   (accept),
            .last     (last_tile_in),
            .psum     (psum_in[PS_LSB +: WIDTH]),
            .threshold(threshold_in[TH_LSB +: ACC_WIDTH]),
            .act      (act_bit)
        );

        assign act_out[O_CH-1-k] = act_bit;
    end

endmodule
